fb_pixel_writer: RTL and testbench

Downstream pixel sink for the frame-clear and rasterizer stages. It accepts one pixel per valid/ready handshake as (x, y, color), computes the linear framebuffer address as y*H_RES + x, and performs a single-word write to the external asynchronous SRAM. It drops off-screen pixels, keeps written and dropped counters, and shares the SRAM bus with other masters through a req/grant pair.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_pixel_writer_if.sv | 28 ++
 rtl/fb_addr_calc.sv | 26 ++
 rtl/fb_pixel_writer.sv | 189 ++++++++++++++++++
 tb/tb_fb_pixel_writer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer constants and writer state type
//
// Purpose : resolution defaults, address/offset widths and the pixel-writer
//           FSM state encoding shared by the writer and the scan-out reader.
// Ports   : none (package).
package fb_pkg;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int FB_ADDR_W   = 20;
  localparam int FB_OFFSET_W = 19;
  localparam int FB_COORD_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT_GNT,
    SETUP,
    STROBE
  } fb_wr_state_t;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// rtl/fb_pixel_writer_if.sv - pixel valid/ready handshake bundle
//
// Purpose : groups the (x, y, color) pixel stream and its handshake.
// Ports   : master drives pix_valid/pix_x/pix_y/pix_color, reads pix_ready;
//           slave is the mirror image (used by fb_pixel_writer).
interface fb_pixel_writer_if
  import fb_pkg::*;
#(
  parameter int COLOR_W = 16
);

  logic                  pix_valid;
  logic                  pix_ready;
  logic [FB_COORD_W-1:0] pix_x;
  logic [FB_COORD_W-1:0] pix_y;
  logic [COLOR_W-1:0]    pix_color;

  modport master (
    output pix_valid, pix_x, pix_y, pix_color,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color,
    output pix_ready
  );

endinterface

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - (x, y) to linear framebuffer offset
//
// Purpose : combinational offset = y*H_RES + x plus an on-screen flag.
//           Shared with the scan-out reader.
// Ports   : x, y      in  pixel column / row
//           offset    out 19-bit linear word offset
//           in_range  out 1 when x < H_RES and y < V_RES
module fb_addr_calc
  import fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic [FB_COORD_W-1:0]  x,
  input  logic [FB_COORD_W-1:0]  y,
  output logic [FB_OFFSET_W-1:0] offset,
  output logic                   in_range
);

  // Constant multiplier; for H_RES = 640 this reduces to (y<<9)+(y<<7).
  always_comb begin
    offset   = FB_OFFSET_W'(y) * FB_OFFSET_W'(H_RES) + FB_OFFSET_W'(x);
    in_range = (int'(x) < H_RES) && (int'(y) < V_RES);
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - pixel sink writing one word per pixel to async SRAM
//
// Purpose : accepts (x, y, color) pixels, drops off-screen ones, arbitrates
//           for the shared SRAM bus and performs a SETUP/STROBE write.
// Ports   : Clk, Reset_n        clock, async active-low reset
//           pix                 pixel handshake (fb_pixel_writer_if.slave)
//           bus_req/bus_grant   shared SRAM bus arbitration
//           SRAM_*              SRAM address, write data, drive enable, strobes
//           cnt_clr             synchronous clear of pix_cnt and drop_cnt
//           pix_cnt, drop_cnt   completed writes (wrapping), drops (saturating)
//           idle                high in IDLE
//           swap_req, back_buf  only with FB_DOUBLE_BUFFER_EN: buffer swap
//                               request and currently selected back buffer
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int COLOR_W = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  fb_pixel_writer_if.slave     pix,
  output logic                 bus_req,
  input  logic                 bus_grant,
  output logic [FB_ADDR_W-1:0] SRAM_ADDR,
  output logic [COLOR_W-1:0]   SRAM_DQ_OUT,
  output logic                 SRAM_DQ_OE,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  input  logic                 cnt_clr,
  output logic [18:0]          pix_cnt,
  output logic [7:0]           drop_cnt,
  output logic                 idle
`ifdef FB_DOUBLE_BUFFER_EN
  ,
  input  logic                 swap_req,
  output logic                 back_buf
`endif
);

  fb_wr_state_t state, state_n;

  logic [FB_COORD_W-1:0]  x_q, y_q;
  logic [COLOR_W-1:0]     color_q;
  logic [FB_OFFSET_W-1:0] offset;
  logic                   in_range;
  logic [FB_ADDR_W-1:0]   addr_q;
  logic [COLOR_W-1:0]     data_q;
  logic                   accept;
  logic                   buf_sel;

  assign accept = pix.pix_valid && pix.pix_ready;

  fb_addr_calc #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_addr_calc (
    .x        (x_q),
    .y        (y_q),
    .offset   (offset),
    .in_range (in_range)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Strobes are a pure decode of the state register, so an async reset
  // returns WE_N high immediately and abandons any write in flight.
  always_comb begin
    state_n       = state;
    pix.pix_ready = 1'b0;
    idle          = 1'b0;
    bus_req       = 1'b0;
    SRAM_CE_N     = 1'b1;
    SRAM_WE_N     = 1'b1;
    SRAM_UB_N     = 1'b1;
    SRAM_LB_N     = 1'b1;
    SRAM_DQ_OE    = 1'b0;
    case (state)
      IDLE: begin
        pix.pix_ready = 1'b1;
        idle          = 1'b1;
        if (pix.pix_valid) state_n = CALC;
      end
      CALC: begin
        if (!in_range) begin
          state_n = IDLE;
        end else begin
          bus_req = 1'b1;
          state_n = bus_grant ? SETUP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        bus_req = 1'b1;
        if (bus_grant) state_n = SETUP;
      end
      SETUP: begin
        bus_req    = 1'b1;
        SRAM_CE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        SRAM_DQ_OE = 1'b1;
        state_n    = STROBE;
      end
      STROBE: begin
        // Accepting here overlaps the next CALC with this write cycle,
        // giving one pixel every three cycles when streaming.
        pix.pix_ready = 1'b1;
        bus_req       = 1'b1;
        SRAM_CE_N     = 1'b0;
        SRAM_WE_N     = 1'b0;
        SRAM_UB_N     = 1'b0;
        SRAM_LB_N     = 1'b0;
        SRAM_DQ_OE    = 1'b1;
        state_n       = pix.pix_valid ? CALC : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pixel capture and the SRAM address/data registers. The address and data
  // only change for in-range pixels so the bus holds its last values while
  // idle or while a dropped pixel passes through CALC.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        x_q     <= pix.pix_x;
        y_q     <= pix.pix_y;
        color_q <= pix.pix_color;
      end
      if (state == CALC && in_range) begin
        addr_q <= {buf_sel, offset};
        data_q <= color_q;
      end
    end
  end

  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_OUT = data_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_cnt  <= '0;
      drop_cnt <= '0;
    end else if (cnt_clr) begin
      pix_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (state == STROBE) pix_cnt <= pix_cnt + 19'd1;
      if (state == CALC && !in_range && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic swap_pend;

  // The swap is deferred to IDLE or STROBE so a pixel already past CALC
  // finishes in the buffer it captured. A request arriving on the apply
  // edge stays pending for the next opportunity.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      back_buf  <= 1'b0;
      swap_pend <= 1'b0;
    end else if (swap_pend && (state == IDLE || state == STROBE)) begin
      back_buf  <= ~back_buf;
      swap_pend <= swap_req;
    end else if (swap_req) begin
      swap_pend <= 1'b1;
    end
  end

  assign buf_sel = back_buf;
`else
  assign buf_sel = 1'b0;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - directed self-checking bench for fb_pixel_writer
module tb_fb_pixel_writer;

  logic        Clk;
  logic        Reset_n;
  logic        bus_grant;
  logic        cnt_clr;
  wire         bus_req;
  wire  [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ_OUT;
  wire         SRAM_DQ_OE, SRAM_CE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  wire  [18:0] pix_cnt;
  wire  [7:0]  drop_cnt;
  wire         idle;
`ifdef FB_DOUBLE_BUFFER_EN
  logic        swap_req;
  wire         back_buf;
`endif

  fb_pixel_writer_if #(.COLOR_W(16)) pif ();

  fb_pixel_writer #(
    .H_RES   (640),
    .V_RES   (480),
    .COLOR_W (16)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix         (pif),
    .bus_req     (bus_req),
    .bus_grant   (bus_grant),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ_OUT (SRAM_DQ_OUT),
    .SRAM_DQ_OE  (SRAM_DQ_OE),
    .SRAM_CE_N   (SRAM_CE_N),
    .SRAM_WE_N   (SRAM_WE_N),
    .SRAM_UB_N   (SRAM_UB_N),
    .SRAM_LB_N   (SRAM_LB_N),
    .cnt_clr     (cnt_clr),
    .pix_cnt     (pix_cnt),
    .drop_cnt    (drop_cnt),
    .idle        (idle)
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    .swap_req    (swap_req),
    .back_buf    (back_buf)
`endif
  );

  // {CE_N, WE_N, UB_N, LB_N, DQ_OE}
  wire [4:0] strb = {SRAM_CE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE};
  localparam logic [4:0] S_OFF    = 5'b11110;
  localparam logic [4:0] S_SETUP  = 5'b01001;
  localparam logic [4:0] S_STROBE = 5'b00001;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int we_cnt = 0;
  int ce_cnt = 0;
  logic [19:0] we_addr [0:63];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (!SRAM_WE_N) begin
      we_addr[we_cnt % 64] <= SRAM_ADDR;
      we_cnt <= we_cnt + 1;
    end
    if (!SRAM_CE_N) ce_cnt <= ce_cnt + 1;
  end

  // Presents a pixel and returns #1 after the accepting edge.
  task automatic send_pixel(input int x, input int y, input logic [15:0] c);
    int guard;
    @(negedge Clk);
    pif.pix_valid = 1'b1;
    pif.pix_x     = 10'(x);
    pif.pix_y     = 10'(y);
    pif.pix_color = c;
    guard = 0;
    while (!pif.pix_ready && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: pix_ready stayed %b, expected 1", pif.pix_ready);
    end
    @(posedge Clk);
    #1;
    pif.pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; bus_grant = 1'b1; cnt_clr = 1'b0;
    pif.pix_valid = 1'b0; pif.pix_x = '0; pif.pix_y = '0; pif.pix_color = '0;
`ifdef FB_DOUBLE_BUFFER_EN
    swap_req = 1'b0;
`endif
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (strb !== S_OFF) begin errors++; $display("FAIL reset_strobes: got %b, expected %b", strb, S_OFF); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b, expected 0", bus_req); end
    checks++; if (SRAM_ADDR !== 20'h0 || SRAM_DQ_OUT !== 16'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h, expected 0/0", SRAM_ADDR, SRAM_DQ_OUT); end
    checks++; if (pif.pix_ready !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL reset_ready_idle: got %b%b, expected 11", pif.pix_ready, idle); end
    checks++; if (pix_cnt !== 19'd0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d, expected 0/0", pix_cnt, drop_cnt); end
`ifdef FB_DOUBLE_BUFFER_EN
    checks++; if (back_buf !== 1'b0) begin errors++; $display("FAIL reset_back_buf: got %b, expected 0", back_buf); end
`endif
  endtask

  task automatic test_single_pixel();
    bus_grant = 1'b1;
    send_pixel(639, 479, 16'hF81F);
    @(negedge Clk); // N+1 CALC
    checks++; if (strb !== S_OFF || bus_req !== 1'b1 || idle !== 1'b0) begin errors++; $display("FAIL single_calc: got strb=%b req=%b idle=%b, expected %b 1 0", strb, bus_req, idle, S_OFF); end
    @(negedge Clk); // N+2 SETUP
    checks++; if (strb !== S_SETUP) begin errors++; $display("FAIL single_setup_strb: got %b, expected %b", strb, S_SETUP); end
    checks++; if (SRAM_ADDR !== 20'h4AFFF || SRAM_DQ_OUT !== 16'hF81F) begin errors++; $display("FAIL single_setup_bus: got %h/%h, expected 4afff/f81f", SRAM_ADDR, SRAM_DQ_OUT); end
    @(negedge Clk); // N+3 STROBE
    checks++; if (strb !== S_STROBE || pif.pix_ready !== 1'b1) begin errors++; $display("FAIL single_strobe: got strb=%b rdy=%b, expected %b 1", strb, pif.pix_ready, S_STROBE); end
    checks++; if (SRAM_ADDR !== 20'h4AFFF) begin errors++; $display("FAIL single_strobe_addr: got %h, expected 4afff", SRAM_ADDR); end
    @(negedge Clk); // N+4 IDLE
    checks++; if (strb !== S_OFF || idle !== 1'b1) begin errors++; $display("FAIL single_after: got strb=%b idle=%b, expected %b 1", strb, idle, S_OFF); end
    checks++; if (pix_cnt !== 19'd1) begin errors++; $display("FAIL single_pix_cnt: got %0d, expected 1", pix_cnt); end
    checks++; if (SRAM_ADDR !== 20'h4AFFF || bus_req !== 1'b0) begin errors++; $display("FAIL single_hold: got addr=%h req=%b, expected 4afff 0", SRAM_ADDR, bus_req); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [0:9];
    int n, guard, w0, ex, ey;
    logic idle_seen;
    bus_grant = 1'b1;
    n = 0; guard = 0; idle_seen = 1'b0;
    w0 = we_cnt;
    @(posedge Clk); #1;
    pif.pix_valid = 1'b1; pif.pix_x = 10'd10; pif.pix_y = 10'd5; pif.pix_color = 16'h1000;
    while (n < 10 && guard < 200) begin
      @(negedge Clk);
      guard++;
      if (n > 0 && idle) idle_seen = 1'b1;
      if (pif.pix_ready) begin
        acc_cyc[n] = cyc;
        n++;
        @(posedge Clk); #1;
        if (n < 10) begin
          pif.pix_x = 10'(10 + n * 50);
          pif.pix_y = 10'(5 + n * 2);
          pif.pix_color = 16'(16'h1000 + n);
        end else begin
          pif.pix_valid = 1'b0;
        end
      end
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL b2b_accepts: got %0d, expected 10", n); end
    repeat (5) @(negedge Clk);
    checks++; if (idle_seen !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got %b, expected 0", idle_seen); end
    for (int i = 1; i < 10; i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d, expected 3", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    checks++; if (we_cnt - w0 !== 10) begin errors++; $display("FAIL b2b_we_pulses: got %0d, expected 10", we_cnt - w0); end
    for (int i = 0; i < 10; i++) begin
      ex = 10 + i * 50; ey = 5 + i * 2;
      checks++; if (we_addr[(w0 + i) % 64] !== 20'(ey * 640 + ex)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h, expected %h", i, we_addr[(w0 + i) % 64], 20'(ey * 640 + ex)); end
    end
    checks++; if (pix_cnt !== 19'd11) begin errors++; $display("FAIL b2b_pix_cnt: got %0d, expected 11", pix_cnt); end
  endtask

  task automatic test_grant_wait();
    bus_grant = 1'b0;
    send_pixel(0, 1, 16'hABCD);
    @(negedge Clk); // N+1 CALC
    checks++; if (bus_req !== 1'b1 || strb !== S_OFF) begin errors++; $display("FAIL gnt_calc: got req=%b strb=%b, expected 1 %b", bus_req, strb, S_OFF); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge Clk); // WAIT_GNT
      checks++; if (bus_req !== 1'b1 || SRAM_CE_N !== 1'b1 || pif.pix_ready !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL gnt_wait[%0d]: got req=%b ce_n=%b rdy=%b idle=%b, expected 1 1 0 0", k, bus_req, SRAM_CE_N, pif.pix_ready, idle); end
    end
    @(posedge Clk); #1 bus_grant = 1'b1;
    @(negedge Clk); // N+6 still WAIT_GNT, grant now seen
    checks++; if (strb !== S_OFF || bus_req !== 1'b1) begin errors++; $display("FAIL gnt_seen: got strb=%b req=%b, expected %b 1", strb, bus_req, S_OFF); end
    @(negedge Clk); // N+7 SETUP
    checks++; if (strb !== S_SETUP || SRAM_ADDR !== 20'd640) begin errors++; $display("FAIL gnt_setup: got strb=%b addr=%h, expected %b 280", strb, SRAM_ADDR, S_SETUP); end
    @(negedge Clk); // N+8 STROBE
    checks++; if (strb !== S_STROBE || SRAM_ADDR !== 20'd640 || SRAM_DQ_OUT !== 16'hABCD) begin errors++; $display("FAIL gnt_strobe: got strb=%b addr=%h data=%h, expected %b 280 abcd", strb, SRAM_ADDR, SRAM_DQ_OUT, S_STROBE); end
    @(negedge Clk);
    checks++; if (pix_cnt !== 19'd12 || idle !== 1'b1) begin errors++; $display("FAIL gnt_done: got cnt=%0d idle=%b, expected 12 1", pix_cnt, idle); end
  endtask

  task automatic test_drop();
    int c0;
    bus_grant = 1'b1;
    c0 = ce_cnt;
    send_pixel(640, 0, 16'h1111);
    @(negedge Clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL drop_x_req: got %b, expected 0", bus_req); end
    @(negedge Clk);
    checks++; if (drop_cnt !== 8'd1 || idle !== 1'b1) begin errors++; $display("FAIL drop_x: got cnt=%0d idle=%b, expected 1 1", drop_cnt, idle); end
    send_pixel(0, 480, 16'h2222);
    @(negedge Clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL drop_y_req: got %b, expected 0", bus_req); end
    @(negedge Clk);
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_y: got %0d, expected 2", drop_cnt); end
    checks++; if (ce_cnt !== c0 || pix_cnt !== 19'd12 || SRAM_ADDR !== 20'd640) begin errors++; $display("FAIL drop_no_bus: got ce=%0d cnt=%0d addr=%h, expected %0d 12 280", ce_cnt, pix_cnt, SRAM_ADDR, c0); end
    send_pixel(640, 0, 16'h3333);
    repeat (2) @(negedge Clk);
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL drop_third: got %0d, expected 3", drop_cnt); end
    send_pixel(0, 480, 16'h4444);
    cnt_clr = 1'b1;           // high across the CALC edge of this drop
    @(posedge Clk); #1 cnt_clr = 1'b0;
    @(negedge Clk);
    checks++; if (drop_cnt !== 8'd0 || pix_cnt !== 19'd0) begin errors++; $display("FAIL drop_clr_priority: got %0d/%0d, expected 0/0", drop_cnt, pix_cnt); end
  endtask

  task automatic test_drop_saturate();
    int c0;
    c0 = ce_cnt;
    @(posedge Clk); #1;
    pif.pix_valid = 1'b1; pif.pix_x = 10'd1023; pif.pix_y = 10'd0;
    repeat (520) @(posedge Clk);
    #1 pif.pix_valid = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d, expected 255", drop_cnt); end
    checks++; if (ce_cnt !== c0) begin errors++; $display("FAIL drop_sat_no_bus: got %0d, expected %0d", ce_cnt, c0); end
    cnt_clr = 1'b1;
    @(posedge Clk); #1 cnt_clr = 1'b0;
    @(negedge Clk);
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL drop_clr: got %0d, expected 0", drop_cnt); end
  endtask

`ifdef FB_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    bus_grant = 1'b1;
    send_pixel(1, 0, 16'h00AA);
    @(negedge Clk);            // A in CALC
    swap_req = 1'b1;
    @(posedge Clk); #1 swap_req = 1'b0;
    @(negedge Clk);            // SETUP
    @(negedge Clk);            // STROBE
    checks++; if (strb !== S_STROBE || SRAM_ADDR !== 20'h00001 || back_buf !== 1'b0) begin errors++; $display("FAIL dbuf_a: got strb=%b addr=%h bb=%b, expected %b 00001 0", strb, SRAM_ADDR, back_buf, S_STROBE); end
    @(negedge Clk);
    checks++; if (back_buf !== 1'b1) begin errors++; $display("FAIL dbuf_toggle: got %b, expected 1", back_buf); end
    send_pixel(1, 0, 16'h00BB);
    repeat (3) @(negedge Clk);
    checks++; if (strb !== S_STROBE || SRAM_ADDR !== 20'h80001) begin errors++; $display("FAIL dbuf_b: got strb=%b addr=%h, expected %b 80001", strb, SRAM_ADDR, S_STROBE); end
  endtask
`endif

  task automatic test_reset_midwrite();
    bus_grant = 1'b1;
    send_pixel(5, 5, 16'h5555);
    repeat (3) @(negedge Clk);  // STROBE
    checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL midrst_pre: got we_n=%b, expected 0", SRAM_WE_N); end
    Reset_n = 1'b0;
    #1;
    checks++; if (strb !== S_OFF || idle !== 1'b1 || pif.pix_ready !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL midrst_async: got strb=%b idle=%b rdy=%b req=%b, expected %b 1 1 0", strb, idle, pif.pix_ready, bus_req, S_OFF); end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++; if (pix_cnt !== 19'd0 || SRAM_ADDR !== 20'h0 || idle !== 1'b1) begin errors++; $display("FAIL midrst_after: got cnt=%0d addr=%h idle=%b, expected 0 0 1", pix_cnt, SRAM_ADDR, idle); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_grant_wait();
    test_drop();
    test_drop_saturate();
`ifdef FB_DOUBLE_BUFFER_EN
    test_double_buffer();
`endif
    test_reset_midwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule
